// File: rtl/izh_scheduler_if.sv
// Operand/result bus to the shared Izhikevich datapath plus the spike event
// valid/ready handshake toward the spike router.
interface izh_scheduler_if #(
  parameter int IDX_W = 2
);
  logic [7:0]       dp_v;
  logic [15:0]      dp_u;
  logic [7:0]       dp_current;
  logic [7:0]       dp_v_next;
  logic [15:0]      dp_u_next;
  logic             dp_spike;
  logic             spike_valid;
  logic [IDX_W-1:0] spike_id;
  logic             spike_ready;

  modport master (
    output dp_v, dp_u, dp_current, spike_valid, spike_id,
    input  dp_v_next, dp_u_next, dp_spike, spike_ready
  );

  modport slave (
    input  dp_v, dp_u, dp_current, spike_valid, spike_id,
    output dp_v_next, dp_u_next, dp_spike, spike_ready
  );
endinterface

// File: rtl/izh_scheduler.sv
// Steps N_NEURONS virtual Izhikevich neurons through one shared external
// datapath per tick, queueing spike indices in a small FIFO.
module izh_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             cur_we,
  input  logic [IDX_W-1:0] cur_addr,
  input  logic [7:0]       cur_data,
  izh_scheduler_if.master  bus,
  output logic             busy,
  output logic             step_done,
  output logic             overrun,
  output logic             spike_drop,
  input  logic [IDX_W-1:0] mon_addr,
  output logic [7:0]       mon_v
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RD, WB, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       v_q   [N_NEURONS];
  logic [7:0]       v_d   [N_NEURONS];
  logic [15:0]      u_q   [N_NEURONS];
  logic [15:0]      u_d   [N_NEURONS];
  logic [7:0]       cur_q [N_NEURONS];
  logic [7:0]       cur_d [N_NEURONS];
  logic [7:0]       dp_v_q, dp_v_d;
  logic [15:0]      dp_u_q, dp_u_d;
  logic [7:0]       dp_cur_q, dp_cur_d;
  logic             busy_q, busy_d;
  logic             step_done_q, step_done_d;
  logic             overrun_q, overrun_d;
  logic             spike_drop_q, spike_drop_d;
  logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, full, do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    v_d          = v_q;
    u_d          = u_q;
    cur_d        = cur_q;
    dp_v_d       = dp_v_q;
    dp_u_d       = dp_u_q;
    dp_cur_d     = dp_cur_q;
    overrun_d    = overrun_q;
    spike_drop_d = spike_drop_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    push         = 1'b0;
    do_push      = 1'b0;

    // RD reads cur_q before this edge, so a same-cycle write lands next step.
    if (cur_we && (int'(cur_addr) < N_NEURONS)) cur_d[cur_addr] = cur_data;

    case (state_q)
      IDLE: begin
        if (tick) begin
          idx_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        dp_v_d   = v_q[idx_q];
        dp_u_d   = u_q[idx_q];
        dp_cur_d = cur_q[idx_q];
        state_d  = WB;
      end
      WB: begin
        v_d[idx_q] = bus.dp_v_next;
        u_d[idx_q] = bus.dp_u_next;
        push       = bus.dp_spike;
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tick && (state_q != IDLE)) overrun_d = 1'b1;

    pop  = (count_q != '0) && bus.spike_ready;
    full = (count_q == CNT_W'(FIFO_DEPTH));
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    if (push && full && !pop) begin
      spike_drop_d = 1'b1;
    end else if (push) begin
      do_push          = 1'b1;
      fifo_d[wr_ptr_q] = idx_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    busy_d      = (state_d != IDLE);
    step_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      v_q          <= '{default: '0};
      u_q          <= '{default: '0};
      cur_q        <= '{default: '0};
      dp_v_q       <= '0;
      dp_u_q       <= '0;
      dp_cur_q     <= '0;
      busy_q       <= 1'b0;
      step_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      spike_drop_q <= 1'b0;
      fifo_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      v_q          <= v_d;
      u_q          <= u_d;
      cur_q        <= cur_d;
      dp_v_q       <= dp_v_d;
      dp_u_q       <= dp_u_d;
      dp_cur_q     <= dp_cur_d;
      busy_q       <= busy_d;
      step_done_q  <= step_done_d;
      overrun_q    <= overrun_d;
      spike_drop_q <= spike_drop_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign bus.dp_v        = dp_v_q;
  assign bus.dp_u        = dp_u_q;
  assign bus.dp_current  = dp_cur_q;
  assign bus.spike_valid = (count_q != '0);
  assign bus.spike_id    = fifo_q[rd_ptr_q];
  assign busy            = busy_q;
  assign step_done       = step_done_q;
  assign overrun         = overrun_q;
  assign spike_drop      = spike_drop_q;
  assign mon_v           = (int'(mon_addr) < N_NEURONS) ? v_q[mon_addr] : '0;
endmodule

// File: tb/tb_izh_scheduler.sv
// Self-checking bench for izh_scheduler: stub datapath (v+1, u+2, masked spikes)
// with a model of stored state and a spike-id scoreboard.
module tb_izh_scheduler;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       tick     = 1'b0;
  logic       cur_we   = 1'b0;
  logic [1:0] cur_addr = '0;
  logic [7:0] cur_data = '0;
  logic [1:0] mon_addr = '0;
  logic       busy, step_done, overrun, spike_drop;
  logic [7:0] mon_v;
  logic [3:0] spike_mask = '0;
  int         stub_cyc;
  logic [1:0] stub_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  cur_m [N];
  logic [7:0]  v_m   [N];
  logic [15:0] u_m   [N];
  logic        drop_m;
  logic [7:0]  exp_cur[$], obs_cur[$], exp_v[$], obs_v[$];
  logic [15:0] exp_u[$], obs_u[$];
  logic [1:0]  exp_spk[$], obs_spk[$];
  logic [1:0]  exp_pop, obs_pop;
  int          done_at;

  izh_scheduler_if #(.IDX_W(2)) bus ();

  izh_scheduler #(.N_NEURONS(N), .IDX_W(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cur_we(cur_we), .cur_addr(cur_addr),
    .cur_data(cur_data), .bus(bus), .busy(busy), .step_done(step_done),
    .overrun(overrun), .spike_drop(spike_drop), .mon_addr(mon_addr), .mon_v(mon_v)
  );

  always #5 clk = ~clk;

  // Stub neuron index: busy cycles alternate RD/WB, so WB of neuron k is count 2k+1.
  always @(posedge clk or posedge reset)
    if (reset || !busy) stub_cyc <= 0;
    else stub_cyc <= stub_cyc + 1;

  assign stub_idx      = 2'((stub_cyc >> 1) & 3);
  assign bus.dp_v_next = bus.dp_v + 8'd1;
  assign bus.dp_u_next = bus.dp_u + 16'd2;
  assign bus.dp_spike  = stub_cyc[0] & spike_mask[stub_idx];

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      cur_m[k] = '0; v_m[k] = '0; u_m[k] = '0;
    end
    drop_m = 1'b0;
    exp_cur.delete(); obs_cur.delete(); exp_v.delete(); obs_v.delete();
    exp_u.delete(); obs_u.delete(); exp_spk.delete(); obs_spk.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    clear_model();
  endtask

  task automatic write_cur(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); cur_we = 1'b1; cur_addr = a; cur_data = d; cur_m[a] = d;
    @(negedge clk); cur_we = 1'b0;
  endtask

  // Drives one tick and records dp operands at each WB; extra events are placed
  // at negedge i after the tick (RD k at 2k+1, WB k at 2k+2, DONE at 2N+1).
  task automatic run_step(input int tick2_at, input int wr_at, input logic [1:0] wr_a,
                          input logic [7:0] wr_d, input int rdy_at);
    exp_cur.delete(); obs_cur.delete(); exp_v.delete(); obs_v.delete();
    exp_u.delete(); obs_u.delete();
    if (rdy_at != 0 && exp_spk.size() > 0) exp_pop = exp_spk.pop_front();
    for (int k = 0; k < N; k++) begin
      exp_cur.push_back(cur_m[k]); exp_v.push_back(v_m[k]); exp_u.push_back(u_m[k]);
      v_m[k] = v_m[k] + 8'd1;
      u_m[k] = u_m[k] + 16'd2;
      if (spike_mask[k]) begin
        if (exp_spk.size() < DEPTH) exp_spk.push_back(2'(k));
        else drop_m = 1'b1;
      end
    end
    if (wr_at != 0) cur_m[wr_a] = wr_d;
    cur_addr = wr_a; cur_data = wr_d;
    @(negedge clk); tick = 1'b1;
    done_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      tick            = (i == tick2_at);
      cur_we          = (i == wr_at);
      bus.spike_ready = (i == rdy_at);
      if (i == rdy_at) obs_pop = bus.spike_id;
      if ((i % 2 == 0) && (i <= 2 * N)) begin
        obs_cur.push_back(bus.dp_current); obs_v.push_back(bus.dp_v); obs_u.push_back(bus.dp_u);
      end
      if (step_done) begin
        done_at = i;
        break;
      end
    end
    tick = 1'b0; cur_we = 1'b0; bus.spike_ready = 1'b0;
  endtask

  task automatic drain();
    obs_spk.delete();
    @(negedge clk); bus.spike_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.spike_valid) break;
      obs_spk.push_back(bus.spike_id);
      @(negedge clk);
    end
    bus.spike_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; #1 reset = 1'b1; #1;
    n_checks++;
    if ({busy, step_done, overrun, spike_drop, bus.spike_valid} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00000",
                         {busy, step_done, overrun, spike_drop, bus.spike_valid});
    end
    n_checks++;
    if ({bus.dp_v, bus.dp_u, bus.dp_current} !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_dp: got %h expected 0", {bus.dp_v, bus.dp_u, bus.dp_current});
    end
    @(negedge clk); reset = 1'b0;
    clear_model();
    for (int k = 0; k < N; k++) write_cur(2'(k), 8'(5 + k));
    spike_mask = 4'b1111;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, bus.spike_valid, bus.dp_current} !== {2'b11, 8'd6}) begin
      n_fail++; $display("[TB] FAIL pre_reset_wb1: got %h expected %h",
                         {busy, bus.spike_valid, bus.dp_current}, {2'b11, 8'd6});
    end
    #2 reset = 1'b1; #1;
    n_checks++;
    if ({busy, bus.spike_valid, bus.dp_current, bus.dp_u, bus.dp_v} !== 34'h0) begin
      n_fail++; $display("[TB] FAIL async_reset: got %h expected 0",
                         {busy, bus.spike_valid, bus.dp_current, bus.dp_u, bus.dp_v});
    end
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      mon_addr = 2'(k); #1;
      n_checks++;
      if (mon_v !== 8'd0) begin
        n_fail++; $display("[TB] FAIL reset_mon_v%0d: got %0d expected 0", k, mon_v);
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, step_done, bus.spike_valid} !== 3'b0) begin
      n_fail++; $display("[TB] FAIL reset_idle: got %b expected 000", {busy, step_done, bus.spike_valid});
    end
    clear_model();
    spike_mask = '0;
  endtask

  task automatic test_sequencing();
    write_cur(2'd0, 8'd10); write_cur(2'd1, 8'd20);
    write_cur(2'd2, 8'd30); write_cur(2'd3, 8'd40);
    for (int s = 0; s < 2; s++) begin
      run_step(0, 0, 2'd0, 8'd0, 0);
      n_checks++;
      if (done_at !== 9) begin
        n_fail++; $display("[TB] FAIL seq_step_done_at: got %0d expected 9", done_at);
      end
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if ({obs_cur[k], obs_v[k], obs_u[k]} !== {exp_cur[k], exp_v[k], exp_u[k]}) begin
          n_fail++; $display("[TB] FAIL seq_dp_n%0d_s%0d: got %h expected %h", k, s,
                             {obs_cur[k], obs_v[k], obs_u[k]}, {exp_cur[k], exp_v[k], exp_u[k]});
        end
      end
      if (s == 0) begin
        for (int k = 0; k < N; k++) begin
          mon_addr = 2'(k); #1;
          n_checks++;
          if (mon_v !== v_m[k]) begin
            n_fail++; $display("[TB] FAIL seq_mon_v%0d: got %0d expected %0d", k, mon_v, v_m[k]);
          end
        end
      end
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("[TB] FAIL back_to_back_overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_spike_fifo();
    spike_mask = 4'b1010;
    run_step(0, 0, 2'd0, 8'd0, 0);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.spike_valid, bus.spike_id} !== {1'b1, 2'd1}) begin
      n_fail++; $display("[TB] FAIL fifo_head_held: got %b expected 101", {bus.spike_valid, bus.spike_id});
    end
    drain();
    n_checks++;
    if (obs_spk.size() != exp_spk.size()) begin
      n_fail++; $display("[TB] FAIL fifo_pop_count: got %0d expected %0d", obs_spk.size(), exp_spk.size());
    end
    for (int k = 0; k < exp_spk.size(); k++) begin
      int o;
      o = (k < obs_spk.size()) ? int'(obs_spk[k]) : -1;
      n_checks++;
      if (o != int'(exp_spk[k])) begin
        n_fail++; $display("[TB] FAIL fifo_id%0d: got %0d expected %0d", k, o, exp_spk[k]);
      end
    end
    exp_spk.delete();
    n_checks++;
    if (bus.spike_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fifo_empty: got %b expected 0", bus.spike_valid);
    end
  endtask

  task automatic test_overflow();
    spike_mask = 4'b1111;
    run_step(0, 0, 2'd0, 8'd0, 0);
    n_checks++;
    if (spike_drop !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ovf_first_step_drop: got %b expected 0", spike_drop);
    end
    run_step(0, 0, 2'd0, 8'd0, 0);
    n_checks++;
    if ({spike_drop, bus.spike_valid} !== {drop_m, 1'b1}) begin
      n_fail++; $display("[TB] FAIL ovf_drop: got %b expected %b", {spike_drop, bus.spike_valid}, {drop_m, 1'b1});
    end
    drain();
    n_checks++;
    if (obs_spk.size() != exp_spk.size()) begin
      n_fail++; $display("[TB] FAIL ovf_pop_count: got %0d expected %0d", obs_spk.size(), exp_spk.size());
    end
    for (int k = 0; k < exp_spk.size(); k++) begin
      int o;
      o = (k < obs_spk.size()) ? int'(obs_spk[k]) : -1;
      n_checks++;
      if (o != int'(exp_spk[k])) begin
        n_fail++; $display("[TB] FAIL ovf_id%0d: got %0d expected %0d", k, o, exp_spk[k]);
      end
    end
    exp_spk.delete();
    spike_mask = '0;
  endtask

  task automatic test_write_race();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("[TB] FAIL race_overrun_pre: got %b expected 0", overrun);
    end
    run_step(3, 5, 2'd2, 8'd99, 0);
    n_checks++;
    if ({overrun, 8'(done_at)} !== {1'b1, 8'd9}) begin
      n_fail++; $display("[TB] FAIL race_overrun_done: got %b/%0d expected 1/9", overrun, done_at);
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if ({obs_cur[k], obs_v[k], obs_u[k]} !== {exp_cur[k], exp_v[k], exp_u[k]}) begin
        n_fail++; $display("[TB] FAIL race_dp_n%0d: got %h expected %h", k,
                           {obs_cur[k], obs_v[k], obs_u[k]}, {exp_cur[k], exp_v[k], exp_u[k]});
      end
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("[TB] FAIL race_single_step: got busy %b expected 0", busy);
      end
    end
    run_step(0, 0, 2'd0, 8'd0, 0);
    n_checks++;
    if (obs_cur[2] !== 8'd99 || exp_cur[2] !== 8'd99) begin
      n_fail++; $display("[TB] FAIL race_next_step_cur2: got %0d expected 99", obs_cur[2]);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    spike_mask = 4'b1111;
    run_step(0, 0, 2'd0, 8'd0, 0);
    spike_mask = 4'b0001;
    run_step(0, 0, 2'd0, 8'd0, 2);
    n_checks++;
    if (obs_pop !== exp_pop) begin
      n_fail++; $display("[TB] FAIL full_pop_head: got %0d expected %0d", obs_pop, exp_pop);
    end
    n_checks++;
    if ({spike_drop, drop_m} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL full_push_pop_drop: got %b expected 0", spike_drop);
    end
    drain();
    n_checks++;
    if (obs_spk.size() != exp_spk.size()) begin
      n_fail++; $display("[TB] FAIL full_count: got %0d expected %0d", obs_spk.size(), exp_spk.size());
    end
    for (int k = 0; k < exp_spk.size(); k++) begin
      int o;
      o = (k < obs_spk.size()) ? int'(obs_spk[k]) : -1;
      n_checks++;
      if (o != int'(exp_spk[k])) begin
        n_fail++; $display("[TB] FAIL full_id%0d: got %0d expected %0d", k, o, exp_spk[k]);
      end
    end
    exp_spk.delete();
  endtask

  initial begin
    bus.spike_ready = 1'b0;
    test_reset();
    test_sequencing();
    test_spike_fifo();
    test_overflow();
    test_write_race();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
